// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_if
//  Description : Bundles the instruction-memory handshake, the queue head
//                outputs and the pipeline control inputs of fetch_queue.
//                master : the fetch_queue side
//                slave  : the instruction memory / pipeline side
//  Ports       : imem_req, imem_addr, imem_ack, imem_rdata   (memory bus)
//                inst_out, pc_plus4_out, inst_valid, count    (queue head)
//                if_take, redirect, redirect_pc               (pipeline ctl)
//  Revision    : 1.0  initial release
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                     imem_req;
    logic [31:0]              imem_addr;
    logic                     imem_ack;
    logic [31:0]              imem_rdata;
    logic [31:0]              inst_out;
    logic [31:0]              pc_plus4_out;
    logic                     inst_valid;
    logic                     if_take;
    logic                     redirect;
    logic [31:0]              redirect_pc;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output imem_req, imem_addr, inst_out, pc_plus4_out, inst_valid, count,
        input  imem_ack, imem_rdata, if_take, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_out, pc_plus4_out, inst_valid, count,
        output imem_ack, imem_rdata, if_take, redirect, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction prefetch queue. Issues one word fetch at a time
//                to instruction memory, buffers returned words with their
//                fetch address + 4, and presents the oldest entry to IF_ID.
//                A redirect flushes the queue and restarts fetching; a
//                response still in flight at that moment is discarded.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-low reset
//                bus  - fetch_queue_if.master (memory bus, head, control)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fetch_queue_if.master       bus
);
    localparam int                 c_ptr_w   = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth   = (c_ptr_w + 1)'(DEPTH);
    localparam logic [c_ptr_w:0]   c_cnt_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // nothing outstanding
        S_WAIT    = 2'd1,   // outstanding, response will be queued
        S_DISCARD = 2'd2    // outstanding, response will be dropped
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [31:0]          r_fetch_pc;
    logic [31:0]          r_req_addr;
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic [31:0]          r_inst_mem [DEPTH];
    logic [31:0]          r_pcp4_mem [DEPTH];

    logic w_issue;
    logic w_push;
    logic w_pop;

    // A request is only issued when a slot is free; since nothing else can
    // push while it is outstanding, that slot stays reserved until the ack.
    assign w_issue = (r_state == S_IDLE) && (r_count < c_depth) && !bus.redirect;
    assign w_push  = (r_state == S_WAIT) && bus.imem_ack && !bus.redirect;
    assign w_pop   = bus.if_take && (r_count != '0) && !bus.redirect;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_ack) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.redirect) begin
                    w_state_nxt = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (bus.imem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fetch PC, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= '0;
            r_req_addr <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (bus.redirect) begin
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + c_ptr_one;
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_one;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_cnt_one;
                    2'b01:   r_count <= r_count - c_cnt_one;
                    default: r_count <= r_count;
                endcase
            end
            // The bus address is frozen at issue so a redirect that moves
            // fetch_pc cannot disturb the request still in flight.
            if (w_issue) begin
                r_req_addr <= r_fetch_pc;
            end
        end
    end

    // Queue storage; contents are qualified by r_count so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= bus.imem_rdata;
            r_pcp4_mem[r_wr_ptr] <= r_fetch_pc + 32'd4;
        end
    end

    assign bus.imem_req     = (r_state != S_IDLE);
    assign bus.imem_addr    = (r_state == S_IDLE) ? r_fetch_pc : r_req_addr;
    assign bus.inst_valid   = (r_count != '0);
    assign bus.inst_out     = bus.inst_valid ? r_inst_mem[r_rd_ptr] : '0;
    assign bus.pc_plus4_out = bus.inst_valid ? r_pcp4_mem[r_rd_ptr] : '0;
    assign bus.count        = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue. The memory
//                model answers in the same cycle as the request while
//                ack_en is set, returning a word derived from the address.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    logic ack_en;
    int   n_cmp;
    int   n_err;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign bus.imem_ack   = bus.imem_req & ack_en;
    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.if_take     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        rst = 1'b0;
        step();
        step();
    endtask

    initial begin
        logic [31:0] issued [$];
        logic [31:0] exp_pc;
        int          n_pops;

        n_cmp  = 0;
        n_err  = 0;
        ack_en = 1'b1;
        bus.if_take     = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        rst = 1'b0;
        step();
        step();

        // Reset state
        check("rst_req",   32'(bus.imem_req),   32'd0);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_count", 32'(bus.count),      32'd0);
        check("rst_inst",  bus.inst_out,        32'd0);
        check("rst_pcp4",  bus.pc_plus4_out,    32'd0);

        // Fill from address 0 with nothing consumed
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.imem_req && bus.imem_ack) issued.push_back(bus.imem_addr);
        end
        check("fill_nreq", 32'(issued.size()), 32'd4);
        for (int i = 0; i < issued.size() && i < 4; i++)
            check("fill_addr", issued[i], 32'(4 * i));
        check("fill_count", 32'(bus.count),    32'd4);
        check("fill_req",   32'(bus.imem_req), 32'd0);
        check("fill_inst",  bus.inst_out,      mem_word(32'd0));
        check("fill_pcp4",  bus.pc_plus4_out,  32'd4);

        // Continuous consumption from a full queue: strict address order
        bus.if_take = 1'b1;
        exp_pc = 32'd4;
        n_pops = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.inst_valid) begin
                check("drain_pcp4", bus.pc_plus4_out, exp_pc);
                check("drain_inst", bus.inst_out,     mem_word(exp_pc - 32'd4));
                exp_pc = exp_pc + 32'd4;
                n_pops++;
            end
            step();
        end
        check("drain_npops", 32'(n_pops), 32'd13);
        bus.if_take = 1'b0;

        // Redirect while a request is outstanding
        apply_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step();
        ack_en = 1'b0;
        step();
        check("disc_addr0", bus.imem_addr,      32'h8);
        check("disc_cnt0",  32'(bus.count),     32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        check("disc_cnt1",  32'(bus.count),      32'd0);
        check("disc_req1",  32'(bus.imem_req),   32'd1);
        check("disc_addr1", bus.imem_addr,       32'h8);
        check("disc_val1",  32'(bus.inst_valid), 32'd0);
        step();
        check("disc_addr2", bus.imem_addr,       32'h8);
        ack_en = 1'b1;
        step();
        check("disc_req3",  32'(bus.imem_req),   32'd0);
        check("disc_cnt3",  32'(bus.count),      32'd0);
        step();
        check("disc_addr4", bus.imem_addr,       32'h100);
        step();
        check("disc_cnt5",  32'(bus.count),      32'd1);
        check("disc_pcp4",  bus.pc_plus4_out,    32'h104);
        check("disc_inst",  bus.inst_out,        mem_word(32'h100));

        // Redirect coincident with the ack, unaligned target
        apply_reset();
        rst = 1'b1;
        step();
        check("coin_ack", 32'(bus.imem_ack), 32'd1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        step();
        bus.redirect = 1'b0;
        check("coin_cnt", 32'(bus.count),    32'd0);
        check("coin_req", 32'(bus.imem_req), 32'd0);
        step();
        check("coin_addr", bus.imem_addr,     32'h200);
        step();
        check("coin_pcp4", bus.pc_plus4_out,  32'h204);

        // Empty queue pop attempts, then reset with a request in flight
        apply_reset();
        ack_en = 1'b0;
        rst = 1'b1;
        step();
        bus.if_take = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("empty_cnt",  32'(bus.count),      32'd0);
            check("empty_val",  32'(bus.inst_valid), 32'd0);
            check("empty_inst", bus.inst_out,        32'd0);
        end
        bus.if_take = 1'b0;
        check("mid_req_pre", 32'(bus.imem_req), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_req_rst", 32'(bus.imem_req), 32'd0);
        step();
        ack_en = 1'b1;
        rst = 1'b1;
        step();
        check("mid_addr", bus.imem_addr,     32'd0);
        step();
        check("mid_cnt",  32'(bus.count),    32'd1);
        check("mid_pcp4", bus.pc_plus4_out,  32'd4);

        // Redirect from IDLE to the top of the address space
        apply_reset();
        rst = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        check("wrap_req0",  32'(bus.imem_req), 32'd0);
        step();
        check("wrap_addr1", bus.imem_addr,     32'hFFFF_FFFC);
        step();
        check("wrap_pcp4",  bus.pc_plus4_out,  32'd0);
        check("wrap_val",   32'(bus.inst_valid), 32'd1);
        step();
        check("wrap_addr2", bus.imem_addr,     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, 4, number of instruction-queue entries; power of two, 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory, level, held until imem_ack.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address, stable while imem_req=1.
REQ-006 Port: imem_ack  input  1  one-cycle pulse, imem_rdata valid this cycle.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: inst_out  output  32  head-of-queue instruction, feeds IF_ID instruction input.
REQ-009 Port: pc_plus4_out  output  32  head-of-queue fetch address + 4, feeds IF_ID pc input.
REQ-010 Port: inst_valid  output  1  queue non-empty.
REQ-011 Port: if_take  input  1  pop head this cycle; driven by IF_ID enable.
REQ-012 Port: redirect  input  1  branch/jump taken; flush and refetch.
REQ-013 Port: redirect_pc  input  32  new fetch address.
REQ-014 Port: count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-015 Internal fetch_pc register; imem_addr shall equal fetch_pc.
REQ-016 FSM states: IDLE (no request outstanding), WAIT (request outstanding, response kept), DISCARD (request outstanding, response dropped).
REQ-017 IDLE -> WAIT, imem_req=1 next cycle, when count<DEPTH and redirect=0; else stay IDLE, imem_req=0.
REQ-018 WAIT, imem_ack=1, redirect=0: push {imem_rdata, fetch_pc+4}; fetch_pc += 4; -> IDLE.
REQ-019 At most one request outstanding; imem_req shall deassert the cycle after imem_ack; minimum issue interval 2 cycles.
REQ-020 Queue shall never overflow: a request issues only with a free slot, reserved until ack or flush.
REQ-021 inst_valid = (count != 0); inst_out and pc_plus4_out combinational from head; when empty both shall be 0 (NOP).
REQ-022 if_take with inst_valid=1: pop head, count-1; if_take with inst_valid=0: ignored, no underflow.
REQ-023 Push and pop in same cycle: count unchanged, order preserved.
REQ-024 Read/write pointers wrap modulo DEPTH.
REQ-025 redirect=1 (any state): count<=0, pointers<=0, fetch_pc<={redirect_pc[31:2],2'b00}; if_take and any push that cycle ignored.
REQ-026 redirect in WAIT without ack: -> DISCARD; imem_req stays 1 with old imem_addr until ack.
REQ-027 redirect coincident with imem_ack (WAIT or DISCARD): response dropped, -> IDLE.
REQ-028 DISCARD, imem_ack=1: response dropped, no push, fetch_pc unchanged, -> IDLE.
REQ-029 redirect in DISCARD without ack: stay DISCARD, fetch_pc updated to newest redirect_pc.
REQ-030 redirect in IDLE: -> IDLE that cycle; request to new address issues next cycle per REQ-017.
REQ-031 fetch_pc arithmetic modulo 2^32; 0xFFFFFFFC+4 wraps to 0.

Reset
REQ-032 rst=0 asynchronously forces: state IDLE, fetch_pc=0, count=0, pointers=0, imem_req=0, inst_valid=0, inst_out=0, pc_plus4_out=0.
REQ-033 Reset asserted while a request is outstanding: outstanding response abandoned; any ack after release and before the first new request ignored.
REQ-034 First request (imem_addr=0) issues in the first clock edge after rst releases.

Verification
REQ-035 Reset release, 1-cycle-latency memory returning addr-derived data, if_take=0 -> requests to 0,4,8,12; count stops at 4; imem_req stays 0; inst_out=mem[0], pc_plus4_out=4.
REQ-036 Full queue, if_take=1 continuously -> one pop per cycle, refill at one per 2 cycles, order 0,4,8,... with no gaps or duplicates in pc_plus4_out.
REQ-037 Request to 8 outstanding, redirect to 0x100 before ack -> count=0 next cycle, imem_addr held 8 until ack, ack data dropped, next request 0x100, first pushed pc_plus4_out=0x104.
REQ-038 redirect to 0x203 in same cycle as imem_ack -> ack data dropped, next imem_addr=0x200.
REQ-039 Empty queue, if_take=1 -> count stays 0, inst_out=0, inst_valid=0.
REQ-040 redirect_pc=0xFFFFFFFC -> fetch 0xFFFFFFFC then 0x0; pc_plus4_out of first entry=0x0.
